bram_loader: RTL and testbench

//  Write-side companion of the instruction/data BRAM: accepts a byte stream
//  (UART/SPI front end) carrying a firmware image, packs bytes into 32-bit

---
 rtl/bram_loader_pkg.sv | 8 +
 rtl/bram_word_packer.sv | 29 ++
 rtl/bram_loader.sv | 105 ++++++++++
 tb/tb_bram_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bram_loader_pkg.sv
// bram_loader_pkg: loader state encoding and byte/word framing constants.
package bram_loader_pkg;
    typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;
    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int LANE_W     = $clog2(WORD_BYTES);
endpackage

// File: rtl/bram_word_packer.sv
// bram_word_packer: 8->32 little-endian assembler; word_valid flags the byte completing a word.
module bram_word_packer
    import bram_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         clear,
    input  logic                         valid,
    input  logic [BYTE_W-1:0]            data,
    output logic [LANE_W-1:0]            lane,
    output logic                         word_valid,
    output logic [WORD_BYTES*BYTE_W-1:0] word
);
    logic [(WORD_BYTES-1)*BYTE_W-1:0] held;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane <= '0;
            held <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (valid) begin
            lane <= lane + 1'b1;
            if (!word_valid) held[lane*BYTE_W +: BYTE_W] <= data;
        end
    end
    // the top lane is never stored: the word is presented while its last byte is on the bus
    assign word_valid = valid && lane == LANE_W'(WORD_BYTES-1);
    assign word = {data, held};
endmodule

// File: rtl/bram_loader.sv
// bram_loader: byte-stream firmware loader packing bytes into BRAM words at sequential addresses.
// Optional trailing checksum word enabled by BRAM_LOADER_CSUM_EN.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_written
);
    state_t state, next;
    logic accept, rearm, word_valid;
    logic [LANE_W-1:0] lane;
    logic [31:0] word;
    logic [CNT_W-1:0] n_words;
`ifdef BRAM_LOADER_CSUM_EN
    localparam state_t FIN = CSUM;
    logic [31:0] csum;
`else
    localparam state_t FIN = DONE;
`endif

    assign in_ready = state == HDR || state == DATA || state == CSUM;
    assign accept   = in_valid && in_ready;
    assign rearm    = start && (state == DONE || state == ERR);
    assign busy     = state == DATA || state == CSUM || (state == HDR && lane != '0);
    assign done     = state == DONE;
    assign err      = state == ERR;

    bram_word_packer u_packer (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (rearm),
        .valid      (accept),
        .data       (in_data),
        .lane       (lane),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= HDR;
        else state <= next;
    end

    always_comb begin
        next = state;
        if (rearm) next = HDR;
        else if (word_valid) begin
            case (state)
                HDR:  next = word == 32'd0 ? FIN : word > 32'(DEPTH_WORDS) ? ERR : DATA;
                DATA: next = words_written + 1'b1 == n_words ? FIN : DATA;
`ifdef BRAM_LOADER_CSUM_EN
                CSUM: next = word == csum ? DONE : ERR;
`endif
                default: next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_we        <= 1'b0;
            mem_addr      <= BASE_ADDR;
            mem_wdata     <= '0;
            words_written <= '0;
            n_words       <= '0;
`ifdef BRAM_LOADER_CSUM_EN
            csum          <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (rearm) begin
                words_written <= '0;
                mem_addr      <= BASE_ADDR;
`ifdef BRAM_LOADER_CSUM_EN
                csum          <= '0;
`endif
            end else if (word_valid && state == HDR) begin
                n_words <= word[CNT_W-1:0];
            end else if (word_valid && state == DATA) begin
                mem_we        <= 1'b1;
                mem_addr      <= BASE_ADDR + 32'({words_written, 2'b00});
                mem_wdata     <= word;
                words_written <= words_written + 1'b1;
`ifdef BRAM_LOADER_CSUM_EN
                csum          <= csum + word;
`endif
            end
        end
    end
endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: directed frames against a cycle-stamped expected-write scoreboard.
module tb_bram_loader;
    logic clk = 0, resetn = 0, start = 0, in_valid = 0;
    logic [7:0] in_data = 0;
    logic in_ready, mem_we, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] words_written;

    always #5 clk = ~clk;

    bram_loader dut (
        .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .err(err), .words_written(words_written)
    );

    typedef struct {int cyc; logic [31:0] a; logic [31:0] d;} wr_t;
    wr_t q[$];
    int ncyc = 0, n_chk = 0, n_fail = 0, nwr = 0;
    logic [31:0] last_a = 0, last_d = 0;
    logic [31:0] pay[1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // every cycle: a write occurs exactly when the scoreboard says so, never otherwise
    always @(negedge clk) begin
        ncyc++;
        if (q.size() > 0 && q[0].cyc == ncyc) begin
            chk("mem_we", mem_we, 1);
            chk("mem_addr", mem_addr, q[0].a);
            chk("mem_wdata", mem_wdata, q[0].d);
            void'(q.pop_front());
        end else chk("mem_we_idle", mem_we, 0);
        if (mem_we) begin
            last_a = mem_addr;
            last_d = mem_wdata;
            nwr++;
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1; in_data = b;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (gap) sync();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit is_pay, input logic [31:0] a);
        for (int k = 0; k < 4; k++) begin
            if (k == 3 && is_pay) q.push_back('{ncyc + 2, a, w});
            send_byte(w[8*k +: 8], gap);
        end
    endtask

    task automatic send_frame(input int n, input int gap);
        logic [31:0] s;
        s = 0;
        send_word(n, gap, 0, 0);
        for (int i = 0; i < n; i++) begin
            send_word(pay[i], gap, 1, 32'(4*i));
            s += pay[i];
        end
`ifdef BRAM_LOADER_CSUM_EN
        send_word(s, gap, 0, 0);
`endif
    endtask

    task automatic chk_end(input string name, input bit ok, input int ww);
        @(negedge clk);
        chk({name, "_done"}, done, ok);
        chk({name, "_err"}, err, !ok);
        chk({name, "_in_ready"}, in_ready, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_words"}, words_written, ww);
        sync();
    endtask

    task automatic chk_idle(input string name);
        @(negedge clk);
        chk({name, "_done"}, done, 0);
        chk({name, "_err"}, err, 0);
        chk({name, "_words"}, words_written, 0);
        chk({name, "_in_ready"}, in_ready, 1);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_addr"}, mem_addr, 0);
        sync();
    endtask

    task automatic pulse_start();
        start = 1; sync(); start = 0;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_we"}, mem_we, 0);
        chk({name, "_addr"}, mem_addr, 0);
        chk({name, "_wdata"}, mem_wdata, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_err"}, err, 0);
        chk({name, "_words"}, words_written, 0);
        chk({name, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;
        resetn = 1;
        sync();

        pay[0] = 32'h44332211; pay[1] = 32'hDDCCBBAA;
        send_frame(2, 0);
        chk_end("t1", 1, 2);
        chk("t1_last_addr", last_a, 32'h4);
        chk("t1_last_data", last_d, 32'hDDCCBBAA);
        pulse_start();
        chk_idle("t1_rearm");

        send_byte(8'h01, 0);
        @(negedge clk);
        chk("t2_busy_hdr", busy, 1);
        sync();
        send_byte(8'h04, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge clk);
        chk("t2_err", err, 1);
        chk("t2_in_ready", in_ready, 0);
        chk("t2_done", done, 0);
        sync();
        chk("t2_no_write", nwr, 2);
        pulse_start();
        chk_idle("t2_rearm");

        pay[0] = 32'h04030201;
        send_frame(1, 3);
        chk_end("t3", 1, 1);
        chk("t3_last_addr", last_a, 32'h0);
        chk("t3_last_data", last_d, 32'h04030201);
        pulse_start();
        chk_idle("t3_rearm");

        send_frame(0, 0);
        chk_end("n0", 1, 0);
        pulse_start();

        pay[0] = 32'h13579BDF;
        send_word(3, 0, 0, 0);
        send_word(pay[0], 0, 1, 0);
        send_byte(8'hEE, 0); send_byte(8'hFF, 0);
        resetn = 0;
        #2;
        chk_reset("t4_reset");
        @(posedge clk); #1;
        resetn = 1;
        pay[0] = 32'hCAFEF00D;
        send_frame(1, 0);
        chk_end("t4", 1, 1);
        chk("t4_last_addr", last_a, 32'h0);
        pulse_start();

`ifdef BRAM_LOADER_CSUM_EN
        pay[0] = 32'hFFFFFFFF; pay[1] = 32'h00000002;
        send_frame(2, 0);
        chk_end("t5_match", 1, 2);
        pulse_start();
        send_word(2, 0, 0, 0);
        send_word(pay[0], 0, 1, 0);
        send_word(pay[1], 0, 1, 4);
        send_word(32'h2, 0, 0, 0);
        chk_end("t5_mismatch", 0, 2);
        pulse_start();
`endif

        for (int i = 0; i < 1024; i++) pay[i] = 32'(i) * 32'h9E3779B9 + 32'h1;
        send_frame(1024, 0);
        chk_end("t6", 1, 1024);
        chk("t6_last_addr", last_a, 32'hFFC);
        repeat (4) sync();
        chk("t6_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
